// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised sequence detector.
//   fill_state_e   : classification of the history fill level
//   DEF_PAT_W      : default pattern length
//   DEF_PATTERN    : default pattern loaded at reset (MSB received first)
//   DEF_CNT_W      : default match counter width
//   fill_state_of  : maps a fill level to its fill state
package seq_det_pkg;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      ARMED   = 2'd2
   } fill_state_e;

   localparam int             DEF_PAT_W   = 4;
   localparam logic [3:0]     DEF_PATTERN = 4'b1101;
   localparam int             DEF_CNT_W   = 8;

   function automatic fill_state_e fill_state_of(input int fill, input int pat_w);
      if (fill == 0)
         return EMPTY;
      else if (fill >= pat_w - 1)
         return ARMED;
      else
         return FILLING;
   endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating event counter with a sticky saturation flag.
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   inc     : count one event this cycle
//   clr     : synchronous clear of count and sat; wins over inc
//   count   : number of events, holds at all-ones
//   sat     : set when count reaches all-ones, held until clr or reset
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count,
   output logic             sat
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
         sat   <= 1'b0;
      end else if (clr) begin
         count <= '0;
         sat   <= 1'b0;
      end else if (inc && (count != CNT_MAX)) begin
         count <= count + 1'b1;
         if (count == (CNT_MAX - 1'b1))
            sat <= 1'b1;
      end
   end

endmodule

// File: rtl/seq_detector_param.sv
// Serial bit-stream matcher with a runtime-loadable PAT_W-bit pattern.
//   clk         : system clock, rising edge
//   reset_n     : asynchronous active-low reset
//   w           : serial data bit, used only when w_valid=1
//   w_valid     : qualifies w this cycle
//   overlap     : 1 = overlapping matches, 0 = history cleared after a match
//   pat_load    : load pat_in as the new pattern; any w this cycle is dropped
//   pat_in      : new pattern, MSB received first
//   cnt_clr     : synchronous clear of match_count/count_sat
//   z           : Mealy match, same cycle as the completing bit
//   z_q         : z registered, one-cycle pulse
//   match_count : saturating number of matches
//   count_sat   : sticky, match_count reached all-ones
//
// Fill-level states (fill register is the state):
//   state   | meaning
//   EMPTY   | fill=0, no accepted bits held
//   FILLING | fill=1..PAT_W-2, collecting bits, no compare possible
//   ARMED   | fill=PAT_W-1, next accepted bit completes a compare window
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int               PAT_W   = DEF_PAT_W,
   parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
   parameter int               CNT_W   = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             w,
   input  logic             w_valid,
   input  logic             overlap,
   input  logic             pat_load,
   input  logic [PAT_W-1:0] pat_in,
   input  logic             cnt_clr,
   output logic             z,
   output logic             z_q,
   output logic [CNT_W-1:0] match_count,
   output logic             count_sat
);

   localparam int               FILL_W   = $clog2(PAT_W);
   localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W - 1);

   logic [PAT_W-1:0]  pattern;
   logic [PAT_W-2:0]  history;
   logic [FILL_W-1:0] fill;
   logic [PAT_W-1:0]  window;
   logic              accept;
   fill_state_e       fill_state;

   // Full compare window: held history plus the bit arriving now. Its low
   // PAT_W-1 bits are also the next history, which keeps PAT_W=2 legal.
   assign window     = {history, w};
   assign accept     = w_valid && !pat_load;
   assign fill_state = fill_state_of(int'(fill), PAT_W);
   assign z          = accept && (fill_state == ARMED) && (window == pattern);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pattern <= PATTERN;
         history <= '0;
         fill    <= '0;
         z_q     <= 1'b0;
      end else begin
         z_q <= z;
         if (pat_load) begin
            pattern <= pat_in;
            history <= '0;
            fill    <= '0;
         end else if (accept) begin
            if (z && !overlap) begin
               history <= '0;
               fill    <= '0;
            end else begin
               history <= window[PAT_W-2:0];
               if (fill != FILL_MAX)
                  fill <= fill + 1'b1;
            end
         end
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_sat_counter (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (z),
      .clr     (cnt_clr),
      .count   (match_count),
      .sat     (count_sat)
   );

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

   logic       clk;
   logic       reset_n;
   logic       w;
   logic       w_valid;
   logic       overlap;
   logic       pat_load;
   logic [3:0] pat_in;
   logic       cnt_clr;

   logic       z,  z_q,  count_sat;
   logic [7:0] match_count;
   logic       z2, z_q2, count_sat2;
   logic [1:0] match_count2;

   int n_total = 0;
   int n_pass  = 0;

   seq_detector_param dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .w           (w),
      .w_valid     (w_valid),
      .overlap     (overlap),
      .pat_load    (pat_load),
      .pat_in      (pat_in),
      .cnt_clr     (cnt_clr),
      .z           (z),
      .z_q         (z_q),
      .match_count (match_count),
      .count_sat   (count_sat)
   );

   seq_detector_param #(.CNT_W(2)) dut_sat (
      .clk         (clk),
      .reset_n     (reset_n),
      .w           (w),
      .w_valid     (w_valid),
      .overlap     (overlap),
      .pat_load    (pat_load),
      .pat_in      (pat_in),
      .cnt_clr     (cnt_clr),
      .z           (z2),
      .z_q         (z_q2),
      .match_count (match_count2),
      .count_sat   (count_sat2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp)
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      else
         n_pass++;
   endtask

   // Called just after a rising edge. Drives one cycle, checks z before the
   // next edge and z_q just after it.
   task automatic step(input logic b, input logic v, input logic exp_z, input string tag);
      w        = b;
      w_valid  = v;
      pat_load = 1'b0;
      @(negedge clk);
      check({tag, ".z"}, z, exp_z);
      @(posedge clk);
      #1;
      check({tag, ".z_q"}, z_q, exp_z);
      cnt_clr = 1'b0;
   endtask

   task automatic do_reset();
      w_valid  = 1'b0;
      pat_load = 1'b0;
      cnt_clr  = 1'b0;
      reset_n  = 1'b0;
      @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   logic [6:0] stream7;
   logic [6:0] exp_ov;
   logic [6:0] exp_nov;
   logic [3:0] s1101;
   logic [3:0] s0110;
   logic [1:0] sat_cnt_exp [4];
   logic       sat_flag_exp [4];

   initial begin
      stream7 = 7'b1101101;
      exp_ov  = 7'b0001001;
      exp_nov = 7'b0001000;
      s1101   = 4'b1101;
      s0110   = 4'b0110;
      sat_cnt_exp  = '{2'd1, 2'd2, 2'd3, 2'd3};
      sat_flag_exp = '{1'b0, 1'b0, 1'b1, 1'b1};

      reset_n  = 1'b0;
      w        = 1'b0;
      w_valid  = 1'b0;
      overlap  = 1'b1;
      pat_load = 1'b0;
      pat_in   = 4'b0000;
      cnt_clr  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst.z",     z,           0);
      check("rst.z_q",   z_q,         0);
      check("rst.cnt",   match_count, 0);
      check("rst.sat",   count_sat,   0);
      reset_n = 1'b1;

      // overlapping: 1101101 matches on bits 4 and 7
      overlap = 1'b1;
      for (int i = 6; i >= 0; i--)
         step(stream7[i], 1'b1, exp_ov[i], $sformatf("ov.b%0d", 7 - i));
      check("ov.cnt", match_count, 2);

      // non-overlapping: only bit 4 matches
      do_reset();
      overlap = 1'b0;
      for (int i = 6; i >= 0; i--)
         step(stream7[i], 1'b1, exp_nov[i], $sformatf("nov.b%0d", 7 - i));
      check("nov.cnt", match_count, 1);

      // gaps of 1..3 idle cycles between bits do not break the sequence
      do_reset();
      overlap = 1'b1;
      for (int i = 3; i >= 0; i--) begin
         step(s1101[i], 1'b1, (i == 0), $sformatf("gap.b%0d", 4 - i));
         if (i > 0)
            for (int g = 0; g < 4 - i; g++)
               step(1'b1, 1'b0, 1'b0, "gap.idle");
      end
      check("gap.cnt", match_count, 1);

      // reset in the middle of a sequence loses the history
      do_reset();
      check("mrst.cnt0", match_count, 0);
      step(1'b1, 1'b1, 1'b0, "mrst.b1");
      step(1'b1, 1'b1, 1'b0, "mrst.b2");
      step(1'b0, 1'b1, 1'b0, "mrst.b3");
      reset_n = 1'b0;
      #1;
      check("mrst.z_q", z_q, 0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      step(1'b1, 1'b1, 1'b0, "mrst.after");
      check("mrst.cnt", match_count, 0);

      // pattern load: the bit in the load cycle is discarded
      do_reset();
      overlap = 1'b0;
      step(1'b1, 1'b1, 1'b0, "pl.pre1");
      step(1'b1, 1'b1, 1'b0, "pl.pre2");
      step(1'b0, 1'b1, 1'b0, "pl.pre3");
      w        = 1'b1;
      w_valid  = 1'b1;
      pat_load = 1'b1;
      pat_in   = 4'b0110;
      @(negedge clk);
      check("pl.load.z", z, 0);
      @(posedge clk);
      #1;
      pat_load = 1'b0;
      for (int i = 3; i >= 0; i--)
         step(s0110[i], 1'b1, (i == 0), $sformatf("pl.new.b%0d", 4 - i));
      for (int i = 3; i >= 0; i--)
         step(s1101[i], 1'b1, 1'b0, $sformatf("pl.old.b%0d", 4 - i));
      check("pl.cnt", match_count, 1);

      // saturation on the 2-bit counter instance; reset restores 1101
      do_reset();
      overlap = 1'b0;
      for (int m = 0; m < 4; m++) begin
         for (int i = 3; i >= 0; i--)
            step(s1101[i], 1'b1, (i == 0), $sformatf("sat.m%0d.b%0d", m + 1, 4 - i));
         check($sformatf("sat.m%0d.cnt", m + 1), match_count2, sat_cnt_exp[m]);
         check($sformatf("sat.m%0d.flag", m + 1), count_sat2, sat_flag_exp[m]);
      end
      check("sat.wide.cnt", match_count, 4);
      check("sat.wide.flag", count_sat, 0);

      // clear coinciding with a 5th match: clear wins, pulse still generated
      for (int i = 3; i >= 1; i--)
         step(s1101[i], 1'b1, 1'b0, "clr.pre");
      cnt_clr = 1'b1;
      w       = 1'b1;
      w_valid = 1'b1;
      @(negedge clk);
      check("clr.z", z2, 1);
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
      w_valid = 1'b0;
      check("clr.z_q", z_q2, 1);
      check("clr.cnt", match_count2, 0);
      check("clr.flag", count_sat2, 0);
      check("clr.wide.cnt", match_count, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
